rv16_fu_ctrl: RTL and testbench

Issue/sequencing controller for the rv16 execute stage. It accepts one ALU operation at a time from decode over a valid/ready handshake and drives the opcode select of the rd functional-unit result mux. It starts and waits on the multi-cycle MUL and DIV units, captures the mux output, and presents the result to register writeback over a second valid/ready handshake. It also handles illegal opcodes, divide-by-zero and unit timeouts, and counts completed operations.

---
 rtl/rv16_pkg.sv | 41 ++++
 rtl/rv16_fu_timeout.sv | 50 +++++
 rtl/rv16_fu_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rv16_fu_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// -----------------------------------------------------------------------------
// rv16_pkg
// Shared definitions for the rv16 execute-stage issue/sequencing controller:
// ALU opcode encodings, controller state and writeback error enums, and small
// opcode-classification helpers.
// -----------------------------------------------------------------------------
package rv16_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } fu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_DIV0    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } wb_err_t;

  // Legal opcodes occupy the contiguous range ADD..OR.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

  // Operations that are handed to a multi-cycle unit and waited on.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/rv16_fu_timeout.sv
// -----------------------------------------------------------------------------
// rv16_fu_timeout
// Loadable up-counter used to bound how long the controller waits on a
// multi-cycle unit. Priority: clear > load > enable.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force count to zero
//   load       : load count from load_val
//   load_val   : value loaded when load is high
//   en         : increment count
//   tc         : terminal count, high while count == TIMEOUT-1
// -----------------------------------------------------------------------------
module rv16_fu_timeout #(
  parameter int TIMEOUT = 64,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/rv16_fu_ctrl.sv
// -----------------------------------------------------------------------------
// rv16_fu_ctrl
// Issue/sequencing controller for the rv16 execute stage. Accepts one ALU op
// from decode, steers the rd result mux, starts and waits on MUL/DIV, captures
// the result and hands it to writeback. Illegal opcodes, divide-by-zero and
// unit timeouts complete with an error code. Completed ops are counted.
//   iss_*        : decode -> controller valid/ready issue handshake
//   fumux_opcode : select for the rd functional-unit result mux
//   fu_result    : rd result mux output
//   mul_*/div_*  : start pulse / done strobe of the multi-cycle units
//   wb_*         : controller -> writeback valid/ready handshake
//   op_count     : completed-op counter (wraps)
// -----------------------------------------------------------------------------
module rv16_fu_ctrl
  import rv16_pkg::*;
#(
  parameter int DATA    = 16,
  parameter int OPCODE  = 4,
  parameter int REGADDR = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [OPCODE-1:0]  iss_opcode,
  input  logic [DATA-1:0]    iss_rs2,
  input  logic [REGADDR-1:0] iss_rd,
  output logic [OPCODE-1:0]  fumux_opcode,
  input  logic [DATA-1:0]    fu_result,
  output logic               mul_start,
  input  logic               mul_done,
  output logic               div_start,
  input  logic               div_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [REGADDR-1:0] wb_rd,
  output logic [DATA-1:0]    wb_data,
  output logic [1:0]         wb_err,
  output logic [15:0]        op_count
);

  fu_state_t          state_q, state_d;
  logic [OPCODE-1:0]  opcode_q, opcode_d;
  logic [DATA-1:0]    rs2_q, rs2_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic [DATA-1:0]    wb_data_q, wb_data_d;
  wb_err_t            wb_err_q, wb_err_d;
  logic [15:0]        op_count_q, op_count_d;

  logic tmo_clear, tmo_en, tmo_tc;

  // ---------------------------------------------------------------------------
  // Opcode decode of the latched opcode. The opcode is zero-extended so the
  // 4-bit encodings can be compared for any OPCODE width; any set bit above
  // bit 3 makes the opcode illegal.
  // ---------------------------------------------------------------------------
  localparam int OPX = OPCODE + 4;

  logic [OPX-1:0] op_ext;
  logic [3:0]     op_lo;
  logic           op_hi_zero, op_legal, op_multi, op_mul, op_div, rs2_zero;

  assign op_ext     = {4'b0000, opcode_q};
  assign op_lo      = op_ext[3:0];
  assign op_hi_zero = ((op_ext >> 4) == '0);
  assign op_legal   = op_hi_zero && is_legal(op_lo);
  assign op_multi   = op_hi_zero && is_multicycle(op_lo);
  assign op_mul     = op_multi && (op_lo == OP_MUL);
  assign op_div     = op_multi && (op_lo == OP_DIV);
  assign rs2_zero   = (rs2_q == '0);

  // Only the unit that was started may complete the op; the other done is
  // ignored.
  logic done_act;
  assign done_act = op_mul ? mul_done : div_done;

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state only.
  // ---------------------------------------------------------------------------
  assign iss_ready    = (state_q == IDLE);
  assign wb_valid     = (state_q == WB);
  assign mul_start    = (state_q == EXEC) && op_mul;
  assign div_start    = (state_q == EXEC) && op_div && !rs2_zero;
  assign fumux_opcode = opcode_q;
  assign wb_rd        = rd_q;
  assign wb_data      = wb_data_q;
  assign wb_err       = wb_err_q;
  assign op_count     = op_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    op_count_d = op_count_q;
    tmo_clear  = 1'b1;
    tmo_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iss_valid) begin
          opcode_d = iss_opcode;
          rs2_d    = iss_rs2;
          rd_d     = iss_rd;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        if (!op_legal) begin
          wb_data_d = '0;
          wb_err_d  = ERR_ILLEGAL;
          state_d   = WB;
        end else if (op_mul) begin
          state_d = WAIT;
        end else if (op_div) begin
          if (rs2_zero) begin
            wb_data_d = '1;
            wb_err_d  = ERR_DIV0;
            state_d   = WB;
          end else begin
            state_d = WAIT;
          end
        end else begin
          wb_data_d = fu_result;
          wb_err_d  = ERR_NONE;
          state_d   = WB;
        end
      end

      WAIT: begin
        // The counter reads 0 in the first WAIT cycle, so terminal count
        // marks the TIMEOUT-th WAIT cycle. A done in that cycle still wins.
        tmo_clear = 1'b0;
        tmo_en    = 1'b1;
        if (done_act) begin
          wb_data_d = fu_result;
          wb_err_d  = ERR_NONE;
          state_d   = WB;
        end else if (tmo_tc) begin
          wb_data_d = '0;
          wb_err_d  = ERR_TIMEOUT;
          state_d   = WB;
        end
      end

      WB: begin
        if (wb_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= ERR_NONE;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
      op_count_q <= op_count_d;
    end
  end

  rv16_fu_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmo_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmo_en),
    .tc       (tmo_tc)
  );

endmodule

// File: tb/tb_rv16_fu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv16_fu_ctrl
// Self-checking bench for rv16_fu_ctrl. Each operation's expected outcome
// (result, error code, completion latency, start pulses) is derived from the
// opcode rules directly, and the completed-op count is tracked as a plain
// integer.
// -----------------------------------------------------------------------------
module tb_rv16_fu_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_opcode;
  logic [15:0] iss_rs2;
  logic [2:0]  iss_rd;
  logic [3:0]  fumux_opcode;
  logic [15:0] fu_result;
  logic        mul_start;
  logic        mul_done;
  logic        div_start;
  logic        div_done;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [1:0]  wb_err;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  rv16_fu_ctrl #(
    .DATA    (16),
    .OPCODE  (4),
    .REGADDR (3),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_opcode   (iss_opcode),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .fumux_opcode (fumux_opcode),
    .fu_result    (fu_result),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .div_start    (div_start),
    .div_done     (div_done),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_err       (wb_err),
    .op_count     (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from issue to writeback acceptance.
  //   d     : cycles after the start pulse at which the active unit's done rises
  //   stray : cycle (relative to EXEC) at which the other unit's done rises
  //   stall : cycles wb_ready stays low in WB
  //   late  : pulse both dones in WB and again in IDLE
  task automatic run_op(input logic [3:0] op, input logic [15:0] rs2, input logic [2:0] rd,
                        input logic [15:0] res, input int d, input int stray,
                        input int stall, input bit late);
    bit          legal, is_mul, is_div, multi;
    logic [15:0] exp_data;
    logic [1:0]  exp_err;
    int          lat;

    legal  = (op <= 4'd6);
    is_mul = (op == 4'd2);
    is_div = (op == 4'd3);
    multi  = is_mul || (is_div && rs2 != 16'd0);
    if (!legal) begin
      exp_data = 16'h0000; exp_err = 2'b01; lat = 1;
    end else if (is_div && rs2 == 16'd0) begin
      exp_data = 16'hFFFF; exp_err = 2'b10; lat = 1;
    end else if (multi) begin
      if (d <= TMO) begin
        exp_data = res; exp_err = 2'b00; lat = d + 1;
      end else begin
        exp_data = 16'h0000; exp_err = 2'b11; lat = TMO + 1;
      end
    end else begin
      exp_data = res; exp_err = 2'b00; lat = 1;
    end

    check("iss_ready_before_issue", iss_ready, 1);
    iss_valid  = 1'b1;
    iss_opcode = op;
    iss_rs2    = rs2;
    iss_rd     = rd;
    tick();
    iss_valid  = 1'b0;
    iss_opcode = 4'($urandom);
    iss_rs2    = 16'($urandom);
    iss_rd     = 3'($urandom);

    // EXEC cycle
    check("exec_iss_ready", iss_ready, 0);
    check("exec_fumux", fumux_opcode, op);
    check("exec_mul_start", mul_start, multi && is_mul);
    check("exec_div_start", div_start, multi && is_div);
    check("exec_wb_valid", wb_valid, 0);
    fu_result = multi ? 16'($urandom) : res;

    for (int k = 1; k <= lat; k++) begin
      tick();
      mul_done = 1'b0;
      div_done = 1'b0;
      if (k == lat) break;
      check("wait_wb_valid", wb_valid, 0);
      check("wait_mul_start", mul_start, 0);
      check("wait_div_start", div_start, 0);
      check("wait_fumux", fumux_opcode, op);
      fu_result = 16'($urandom);
      if (k == d) begin
        fu_result = res;
        if (is_mul) mul_done = 1'b1;
        else        div_done = 1'b1;
      end
      if (k == stray) begin
        if (is_mul) div_done = 1'b1;
        else        mul_done = 1'b1;
      end
    end

    // WB entered exactly at the expected cycle
    check("wb_valid", wb_valid, 1);
    check("wb_data", wb_data, exp_data);
    check("wb_err", wb_err, exp_err);
    check("wb_rd", wb_rd, rd);
    check("wb_iss_ready", iss_ready, 0);

    for (int s = 0; s < stall; s++) begin
      wb_ready  = 1'b0;
      fu_result = 16'($urandom);
      if (late && s == 0) begin
        mul_done = 1'b1;
        div_done = 1'b1;
      end
      tick();
      mul_done = 1'b0;
      div_done = 1'b0;
      check("stall_wb_valid", wb_valid, 1);
      check("stall_wb_data", wb_data, exp_data);
      check("stall_wb_err", wb_err, exp_err);
      check("stall_wb_rd", wb_rd, rd);
    end

    wb_ready = 1'b1;
    tick();
    wb_ready  = 1'b0;
    exp_count = exp_count + 16'd1;
    check("post_wb_valid", wb_valid, 0);
    check("post_iss_ready", iss_ready, 1);
    check("op_count", op_count, exp_count);

    if (late) begin
      mul_done = 1'b1;
      div_done = 1'b1;
      tick();
      mul_done = 1'b0;
      div_done = 1'b0;
      check("late_idle_iss_ready", iss_ready, 1);
      check("late_idle_wb_valid", wb_valid, 0);
      check("late_idle_mul_start", mul_start, 0);
      check("late_idle_op_count", op_count, exp_count);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    iss_valid  = 1'b0;
    iss_opcode = 4'd0;
    iss_rs2    = 16'd0;
    iss_rd     = 3'd0;
    fu_result  = 16'd0;
    mul_done   = 1'b0;
    div_done   = 1'b0;
    wb_ready   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_iss_ready", iss_ready, 1);
    check("rst_fumux", fumux_opcode, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_div_start", div_start, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_op_count", op_count, 0);

    // Directed scenarios
    run_op(4'b0000, 16'h0005, 3'd1, 16'h1234, 0, 0, 0, 1'b0);   // ADD
    run_op(4'b0010, 16'h0003, 3'd2, 16'h0C00, 5, 2, 0, 1'b0);   // MUL, stray div_done
    run_op(4'b0011, 16'h0000, 3'd3, 16'h5555, 0, 0, 0, 1'b0);   // DIV by zero
    run_op(4'b1111, 16'h0001, 3'd4, 16'h7777, 0, 0, 0, 1'b0);   // illegal
    run_op(4'b0111, 16'h0001, 3'd5, 16'h7777, 0, 0, 0, 1'b0);   // illegal
    run_op(4'b0010, 16'h0001, 3'd6, 16'hBEEF, 100, 0, 2, 1'b1); // MUL timeout, late done
    run_op(4'b0011, 16'h0007, 3'd7, 16'h00AB, TMO, 3, 0, 1'b0); // DIV done on last WAIT cycle
    run_op(4'b0011, 16'h0007, 3'd1, 16'h00CD, TMO + 1, 0, 1, 1'b1); // DIV one cycle too late
    run_op(4'b0011, 16'h0009, 3'd2, 16'h1357, 1, 1, 0, 1'b0);   // DIV earliest done

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [15:0] rs2;
      op  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      rs2 = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      run_op(op, rs2, 3'($urandom), 16'($urandom), $urandom_range(1, TMO + 2),
             $urandom_range(1, 10), $urandom_range(0, 3), 1'($urandom));
    end

    // Backpressure then reset mid-WB
    iss_valid  = 1'b1;
    iss_opcode = 4'b0100;
    iss_rs2    = 16'h00FF;
    iss_rd     = 3'd5;
    tick();
    iss_valid = 1'b0;
    fu_result = 16'hA5A5;
    tick();
    check("bp_wb_valid", wb_valid, 1);
    for (int s = 0; s < 10; s++) begin
      fu_result = 16'($urandom);
      tick();
      check("bp_hold_valid", wb_valid, 1);
      check("bp_hold_data", wb_data, 16'hA5A5);
      check("bp_hold_err", wb_err, 0);
      check("bp_hold_rd", wb_rd, 5);
    end
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_count = 16'd0;
    check("rst2_iss_ready", iss_ready, 1);
    check("rst2_fumux", fumux_opcode, 0);
    check("rst2_mul_start", mul_start, 0);
    check("rst2_div_start", div_start, 0);
    check("rst2_wb_valid", wb_valid, 0);
    check("rst2_wb_rd", wb_rd, 0);
    check("rst2_wb_data", wb_data, 0);
    check("rst2_wb_err", wb_err, 0);
    check("rst2_op_count", op_count, exp_count);

    // Controller is usable again after the abort
    run_op(4'b0001, 16'h0002, 3'd3, 16'h0F0F, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
